data_mem_ctrl: RTL and testbench



---
 rtl/cpu_pkg.sv | 13 +
 rtl/data_mem_array.sv | 38 +++
 rtl/data_mem_ctrl.sv | 110 +++++++++++
 tb/tb_data_mem_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the MEM-stage data memory controller.
package cpu_pkg;

  localparam int unsigned WORD_W               = 32;
  localparam int unsigned DMEM_LATENCY_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous word RAM; the read register only updates on reads,
// so it holds the most recent load value.
module data_mem_array
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_rdata;

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      r_mem[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rdata <= '0;
    end else if (en_i && !we_i) begin
      r_rdata <= r_mem[addr_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory controller: fixed-latency load/store against an internal RAM,
// stalling the upstream pipeline while an access is in flight.
module data_mem_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned LATENCY     = DMEM_LATENCY_DEFAULT,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              misalign_o
);

  localparam int unsigned AW          = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CntInit     = 4'(LATENCY - 1);
  localparam bit          SingleCycle = (LATENCY == 1);

  mem_state_t        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [AW-1:0]     r_idx;
  logic [WORD_W-1:0] r_wdata;

  logic              w_idle;
  logic              w_aligned;
  logic              w_accept;
  logic              w_last_busy;
  logic              w_access;
  logic [AW-1:0]     w_idx_in;
  logic [AW-1:0]     w_ram_idx;
  logic              w_ram_we;
  logic [WORD_W-1:0] w_ram_wdata;
  logic              w_unused_addr;

  assign w_idle    = (r_state == IDLE);
  assign w_aligned = (addr_i[1:0] == 2'b00);
  assign w_accept  = w_idle && req_i && w_aligned;
  assign w_idx_in  = addr_i[AW+1:2];

  // High address bits alias onto the RAM by design.
  assign w_unused_addr = ^addr_i[31:AW+2];

  // Counter is loaded with LATENCY-1; the last BUSY cycle is the one whose
  // decrement reaches zero, giving LATENCY stall cycles in total.
  assign w_last_busy = (r_state == BUSY) && (r_cnt == 4'd1);
  assign w_access    = (w_accept && SingleCycle) || w_last_busy;

  // With LATENCY == 1 the access happens on the accept edge, before the latches fill.
  assign w_ram_idx   = w_idle ? w_idx_in : r_idx;
  assign w_ram_we    = w_idle ? we_i     : r_we;
  assign w_ram_wdata = w_idle ? wdata_i  : r_wdata;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we    <= we_i;
            r_idx   <= w_idx_in;
            r_wdata <= wdata_i;
            r_cnt   <= CntInit;
            r_state <= SingleCycle ? DONE : BUSY;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_last_busy) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  data_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (w_access),
    .we_i   (w_ram_we),
    .addr_i (w_ram_idx),
    .wdata_i(w_ram_wdata),
    .rdata_o(rdata_o)
  );

  assign stall_o    = w_accept || (r_state == BUSY);
  assign done_o     = (r_state == DONE);
  assign misalign_o = w_idle && req_i && !w_aligned;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance at LATENCY=3, one at LATENCY=1.
module tb_data_mem_ctrl;
  import cpu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        req3, we3, stall3, done3, mis3;
  logic [31:0] addr3, wdata3, rdata3;
  logic        req1, we1, stall1, done1, mis1;
  logic [31:0] addr1, wdata1, rdata1;

  int n_pass  = 0;
  int n_total = 0;

  data_mem_ctrl #(.LATENCY(3), .DEPTH_WORDS(256)) dut3 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req3), .we_i(we3), .addr_i(addr3), .wdata_i(wdata3),
    .stall_o(stall3), .done_o(done3), .rdata_o(rdata3), .misalign_o(mis3)
  );

  data_mem_ctrl #(.LATENCY(1), .DEPTH_WORDS(256)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req1), .we_i(we1), .addr_i(addr1), .wdata_i(wdata1),
    .stall_o(stall1), .done_o(done1), .rdata_o(rdata1), .misalign_o(mis1)
  );

  task automatic drive(input bit sel, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel) begin
      req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req3 = req; we3 = we; addr3 = addr; wdata3 = wdata;
    end
  endtask

  // Issues one request (held through DONE), then one idle cycle; counts stall/done cycles.
  task automatic access(input bit sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int stalls, output int dones,
                        output logic [31:0] rd);
    bit seen;
    stalls = 0; dones = 0; rd = '0; seen = 1'b0;
    @(posedge clk); #1;
    drive(sel, 1'b1, we, addr, wdata);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sel ? stall1 : stall3) stalls++;
      if (sel ? done1 : done3) begin
        dones++;
        rd   = sel ? rdata1 : rdata3;
        seen = 1'b1;
      end
      @(posedge clk); #1;
      if (seen) break;
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    if (sel ? stall1 : stall3) stalls++;
    if (sel ? done1 : done3) dones++;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    #2;
    n_total++; if (stall3 !== 1'b0) $display("FAIL reset_stall3 got %b want 0", stall3); else n_pass++;
    n_total++; if (done3 !== 1'b0) $display("FAIL reset_done3 got %b want 0", done3); else n_pass++;
    n_total++; if (mis3 !== 1'b0) $display("FAIL reset_mis3 got %b want 0", mis3); else n_pass++;
    n_total++; if (rdata3 !== 32'h0) $display("FAIL reset_rdata3 got %h want 0", rdata3); else n_pass++;
    n_total++; if (done1 !== 1'b0) $display("FAIL reset_done1 got %b want 0", done1); else n_pass++;
    n_total++; if (rdata1 !== 32'h0) $display("FAIL reset_rdata1 got %h want 0", rdata1); else n_pass++;
    #9 rst_n = 1'b1;
    n_total++;
    if (dut3.r_state !== IDLE) $display("FAIL reset_state got %0d want IDLE", dut3.r_state);
    else n_pass++;
  endtask

  task automatic test_store_load();
    int s, d;
    logic [31:0] rd;
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, s, d, rd);
    n_total++; if (s != 3) $display("FAIL st_stalls got %0d want 3", s); else n_pass++;
    n_total++; if (d != 1) $display("FAIL st_dones got %0d want 1", d); else n_pass++;
    access(1'b0, 1'b0, 32'h10, 32'h0, s, d, rd);
    n_total++; if (s != 3) $display("FAIL ld_stalls got %0d want 3", s); else n_pass++;
    n_total++; if (d != 1) $display("FAIL ld_dones got %0d want 1", d); else n_pass++;
    n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL ld_rdata got %h want deadbeef", rd); else n_pass++;
  endtask

  task automatic test_misalign();
    int m, d;
    m = 0; d = 0;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h13, 32'h0);
    @(negedge clk);
    n_total++; if (mis3 !== 1'b1) $display("FAIL mis_pulse got %b want 1", mis3); else n_pass++;
    n_total++; if (stall3 !== 1'b0) $display("FAIL mis_stall got %b want 0", stall3); else n_pass++;
    if (done3) d++;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mis3) m++;
      if (done3) d++;
    end
    n_total++; if (m != 0) $display("FAIL mis_width got %0d extra want 0", m); else n_pass++;
    n_total++; if (d != 0) $display("FAIL mis_done got %0d want 0", d); else n_pass++;
    n_total++; if (rdata3 !== 32'hDEADBEEF) $display("FAIL mis_rdata got %h want deadbeef", rdata3);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int s, d;
    logic [31:0] rd;
    access(1'b0, 1'b1, 32'h400, 32'h1234, s, d, rd);
    access(1'b0, 1'b0, 32'h000, 32'h0, s, d, rd);
    n_total++; if (rd !== 32'h1234) $display("FAIL wrap_rdata got %h want 00001234", rd); else n_pass++;
  endtask

  task automatic test_reset_mid_store();
    int s, d;
    logic [31:0] rd;
    access(1'b0, 1'b1, 32'h20, 32'h55, s, d, rd);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hAA);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++;
    if (dut3.r_state !== BUSY) $display("FAIL rst_pre_state got %0d want BUSY", dut3.r_state);
    else n_pass++;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n_total++; if (stall3 !== 1'b0) $display("FAIL rst_stall got %b want 0", stall3); else n_pass++;
    n_total++; if (done3 !== 1'b0) $display("FAIL rst_done got %b want 0", done3); else n_pass++;
    n_total++; if (mis3 !== 1'b0) $display("FAIL rst_mis got %b want 0", mis3); else n_pass++;
    n_total++; if (rdata3 !== 32'h0) $display("FAIL rst_rdata got %h want 0", rdata3); else n_pass++;
    n_total++;
    if (dut3.r_state !== IDLE) $display("FAIL rst_state got %0d want IDLE", dut3.r_state);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 1'b0, 32'h20, 32'h0, s, d, rd);
    n_total++; if (rd !== 32'h55) $display("FAIL rst_no_commit got %h want 00000055", rd); else n_pass++;
  endtask

  task automatic test_req_held();
    int s, d;
    logic [31:0] rd;
    access(1'b0, 1'b1, 32'h30, 32'h77, s, d, rd);
    n_total++; if (d != 1) $display("FAIL held_dones got %0d want 1", d); else n_pass++;
    n_total++; if (s != 3) $display("FAIL held_stalls got %0d want 3", s); else n_pass++;
    n_total++;
    if (dut3.r_state !== IDLE) $display("FAIL held_state got %0d want IDLE", dut3.r_state);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s, d;
    logic [31:0] rd;
    access(1'b1, 1'b1, 32'h0, 32'h11111111, s, d, rd);
    n_total++; if (s != 1) $display("FAIL l1_stalls got %0d want 1", s); else n_pass++;
    access(1'b1, 1'b1, 32'h4, 32'h22222222, s, d, rd);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_total++; if ({stall1, done1} !== 2'b10) $display("FAIL b2b_c0 got %b want 10", {stall1, done1});
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if ({stall1, done1} !== 2'b01) $display("FAIL b2b_c1 got %b want 01", {stall1, done1});
    else n_pass++;
    n_total++; if (rdata1 !== 32'h11111111) $display("FAIL b2b_rd0 got %h want 11111111", rdata1);
    else n_pass++;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
    @(negedge clk);
    n_total++; if ({stall1, done1} !== 2'b10) $display("FAIL b2b_c2 got %b want 10", {stall1, done1});
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if ({stall1, done1} !== 2'b01) $display("FAIL b2b_c3 got %b want 01", {stall1, done1});
    else n_pass++;
    n_total++; if (rdata1 !== 32'h22222222) $display("FAIL b2b_rd1 got %h want 22222222", rdata1);
    else n_pass++;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_total++; if ({stall1, done1} !== 2'b00) $display("FAIL b2b_idle got %b want 00", {stall1, done1});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_misalign();
    test_wrap();
    test_reset_mid_store();
    test_req_held();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
